// File: rtl/vedic_pkg.sv
// Shared width helpers for the pipelined Vedic multiplier.
package vedic_pkg;

  // Width of the optional zero-bypass beat counter.
  localparam int SKIP_CNT_W = 32;

  // Product width for W-bit operands.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Half-operand width used by the Urdhva partial multipliers.
  function automatic int half_w(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/vedic_half_mult.sv
// Combinational HxH unsigned Urdhva-Tiryagbhyam (vertical and crosswise) multiplier.
// Each product column k sums the cross terms a[i]&b[j] with i+j==k; the weighted
// column sums are then accumulated, which resolves the carries between columns.
module vedic_half_mult #(
  parameter int H = 4
) (
  input  logic [H-1:0]   a_i,
  input  logic [H-1:0]   b_i,
  output logic [2*H-1:0] p_o
);

  localparam int PW = 2 * H;
  localparam int CW = $clog2(H + 1);

  logic [CW-1:0] col;

  // Column-wise cross products, accumulated into the full 2H-bit product.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned (no latch).
    p_o = '0;
    col = '0;
    for (int k = 0; k < 2 * H - 1; k++) begin
      col = '0;
      for (int i = 0; i < H; i++) begin
        for (int j = 0; j < H; j++) begin
          if (i + j == k) col = col + CW'(a_i[i] & b_i[j]);
        end
      end
      p_o = p_o + (PW'(col) << k);
    end
  end

endmodule

// File: rtl/vedic_mult_axis_pipe.sv
// 3-stage pipelined unsigned Vedic multiplier with AXI-Stream ports and full backpressure.
// S1: operands + sideband + zero flag. S2: four HxH partial products. S3: final add.
// Zero operands bypass the multiplier: S2 partials hold and the result is forced to 0.
// Optional feature macro: VEDIC_SKIP_CNT_EN adds a saturating count of bypassed beats.
module vedic_mult_axis_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TUSER_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*WIDTH-1:0]    s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [TUSER_W-1:0]    s_axis_tuser,
  output logic [2*WIDTH-1:0]    m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [TUSER_W-1:0]    m_axis_tuser,
  output logic                  m_axis_tskip
`ifdef VEDIC_SKIP_CNT_EN
  ,
  input  logic                  skip_cnt_clr,
  output logic [SKIP_CNT_W-1:0] skip_cnt
`endif
);

  localparam int PW = prod_w(WIDTH);
  localparam int H  = half_w(WIDTH);
  localparam int MW = 2 * H + 1;

  typedef struct packed {
    logic [PW-1:0]      data;
    logic               last;
    logic [TUSER_W-1:0] user;
    logic               skip;
  } beat_t;

  logic          v1_q, v2_q, v3_q;
  beat_t         s1_q, s2_q, s3_q;
  beat_t         s1_d, s3_d;
  logic [PW-1:0] pp_d;
  logic [MW-1:0] mid_q, mid_d;
  logic          adv1, adv2, adv3;

  logic [WIDTH-1:0] a1, b1;
  logic [H-1:0]     a_lo, a_hi, b_lo, b_hi;
  logic [2*H-1:0]   pp_ll, pp_hh, pp_lh, pp_hl;

  // Combinational ready chain: a stage moves when it is empty or its successor moves.
  assign adv3          = !v3_q || m_axis_tready;
  assign adv2          = !v2_q || adv3;
  assign adv1          = !v1_q || adv2;
  assign s_axis_tready = adv1;

  assign a1   = s1_q.data[WIDTH-1:0];
  assign b1   = s1_q.data[PW-1:WIDTH];
  assign a_lo = a1[H-1:0];
  assign a_hi = a1[WIDTH-1:H];
  assign b_lo = b1[H-1:0];
  assign b_hi = b1[WIDTH-1:H];

  vedic_half_mult #(.H(H)) u_ll (.a_i(a_lo), .b_i(b_lo), .p_o(pp_ll));
  vedic_half_mult #(.H(H)) u_hh (.a_i(a_hi), .b_i(b_hi), .p_o(pp_hh));
  vedic_half_mult #(.H(H)) u_lh (.a_i(a_lo), .b_i(b_hi), .p_o(pp_lh));
  vedic_half_mult #(.H(H)) u_hl (.a_i(a_hi), .b_i(b_lo), .p_o(pp_hl));

  // Next-state payloads for each stage.
  always_comb begin
    s1_d.data = s_axis_tdata;
    s1_d.last = s_axis_tlast;
    s1_d.user = s_axis_tuser;
    s1_d.skip = (s_axis_tdata[WIDTH-1:0] == '0) || (s_axis_tdata[PW-1:WIDTH] == '0);
    pp_d      = {pp_hh, pp_ll};
    mid_d     = MW'(pp_lh) + MW'(pp_hl);
    s3_d      = s2_q;
    s3_d.data = s2_q.skip ? '0 : s2_q.data + (PW'(mid_q) << H);
  end

  // Valid bits: bubbles propagate as cleared valids, stalled stages keep theirs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= s_axis_tvalid;
      if (adv2) v2_q <= v1_q;
      if (adv3) v3_q <= v2_q;
    end
  end

  // Payload registers load only for valid beats; S2 partials also hold on zero bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too so all outputs read 0 during and after reset.
      s1_q  <= '0;
      s2_q  <= '0;
      mid_q <= '0;
      s3_q  <= '0;
    end else begin
      if (adv1 && s_axis_tvalid) s1_q <= s1_d;
      if (adv2 && v1_q) begin
        s2_q.last <= s1_q.last;
        s2_q.user <= s1_q.user;
        s2_q.skip <= s1_q.skip;
        if (!s1_q.skip) begin
          s2_q.data <= pp_d;
          mid_q     <= mid_d;
        end
      end
      if (adv3 && v2_q) s3_q <= s3_d;
    end
  end

  assign m_axis_tvalid = v3_q;
  assign m_axis_tdata  = s3_q.data;
  assign m_axis_tlast  = s3_q.last;
  assign m_axis_tuser  = s3_q.user;
  assign m_axis_tskip  = s3_q.skip;

`ifdef VEDIC_SKIP_CNT_EN
  logic [SKIP_CNT_W-1:0] skip_cnt_q;

  // Saturating count of emitted bypass beats; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt_q <= '0;
    end else if (skip_cnt_clr) begin
      skip_cnt_q <= '0;
    end else if (v3_q && m_axis_tready && s3_q.skip && (skip_cnt_q != '1)) begin
      skip_cnt_q <= skip_cnt_q + 1'b1;
    end
  end

  assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_vedic_mult_axis_pipe.sv
// Self-checking bench for vedic_mult_axis_pipe (WIDTH=8, TUSER_W=1).
// Expected beats come from a FIFO scoreboard filled with a*b at every input handshake.
module tb_vedic_mult_axis_pipe;

  localparam int W  = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [0:0]    s_axis_tuser;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [0:0]    m_axis_tuser;
  logic          m_axis_tskip;
`ifdef VEDIC_SKIP_CNT_EN
  logic          skip_cnt_clr;
  logic [31:0]   skip_cnt;
  int            exp_skip_cnt = 0;
`endif

  always #5 clk = ~clk;

  vedic_mult_axis_pipe #(.WIDTH(W), .TUSER_W(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tskip  (m_axis_tskip)
`ifdef VEDIC_SKIP_CNT_EN
    ,
    .skip_cnt_clr  (skip_cnt_clr),
    .skip_cnt      (skip_cnt)
`endif
  );

  typedef struct {
    logic [PW-1:0] data;
    logic          last;
    logic [0:0]    user;
    logic          skip;
  } exp_t;

  exp_t q[$];
  int   out_stamp[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  logic in_fire, out_fire;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned product; zero operands report a bypass beat.
  function automatic exp_t model(input logic [PW-1:0] d, input logic l, input logic [0:0] u);
    exp_t e;
    int   a, b;
    a      = int'(d[W-1:0]);
    b      = int'(d[PW-1:W]);
    e.skip = (a == 0) || (b == 0);
    e.data = PW'(a * b);
    e.last = l;
    e.user = u;
    return e;
  endfunction

  task automatic set_in(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit l, input bit u);
    s_axis_tvalid = v;
    s_axis_tdata  = {b, a};
    s_axis_tlast  = l;
    s_axis_tuser  = u;
  endtask

  // One clock: called #1 after a rising edge with inputs already driven.
  task automatic tick();
    exp_t e;
    bit   have;
    int   inc;
    #1;
    in_fire  = s_axis_tvalid && s_axis_tready;
    out_fire = m_axis_tvalid && m_axis_tready;
    have     = (q.size() != 0);
    inc      = 0;
    if (m_axis_tvalid) begin
      check("beat_expected", 64'(have), 64'd1);
      if (have) begin
        e = q[0];
        check("tdata", 64'(m_axis_tdata), 64'(e.data));
        check("tlast", 64'(m_axis_tlast), 64'(e.last));
        check("tuser", 64'(m_axis_tuser), 64'(e.user));
        check("tskip", 64'(m_axis_tskip), 64'(e.skip));
      end
    end
    if (out_fire) begin
      out_stamp.push_back(cyc);
      if (have) begin
        if (e.skip) inc = 1;
        void'(q.pop_front());
      end
    end
    if (in_fire) q.push_back(model(s_axis_tdata, s_axis_tlast, s_axis_tuser));
`ifdef VEDIC_SKIP_CNT_EN
    exp_skip_cnt = skip_cnt_clr ? 0 : exp_skip_cnt + inc;
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input bit rnd_ready);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    check("drain_idle", 64'(m_axis_tvalid), 64'd0);
    m_axis_tready = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
    check({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
    check({tag, "_tuser"},  64'(m_axis_tuser),  64'd0);
    check({tag, "_tskip"},  64'(m_axis_tskip),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, acc, idx, n;
    logic [7:0]   ra[16];
    logic [7:0]   rb[16];
    logic [0:0]   ru[16];
    logic [15:0]  pp_exp;
    logic [8:0]   mid_exp;

    rst_n         = 1'b0;
    m_axis_tready = 1'b0;
    set_in(0, 8'h00, 8'h00, 0, 0);
`ifdef VEDIC_SKIP_CNT_EN
    skip_cnt_clr  = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    #1;
    check("reset_s_tready", 64'(s_axis_tready), 64'd1);
`ifdef VEDIC_SKIP_CNT_EN
    check("reset_skip_cnt", 64'(skip_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Test 1: 0xFF*0xFF with latency measurement
    m_axis_tready = 1'b1;
    set_in(1, 8'hFF, 8'hFF, 0, 0);
    tick();
    check("t1_accept", 64'(in_fire), 64'd1);
    set_in(0, 8'h00, 8'h00, 0, 0);
    lat = 1;
    while (!m_axis_tvalid && lat < 8) begin
      tick();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_tdata", 64'(m_axis_tdata), 64'hFE01);
    check("t1_tskip", 64'(m_axis_tskip), 64'd0);
    drain(0);

    // Test 2: zero operand bypass; partials keep the 0xFF*0xFF values
    pp_exp  = {8'(15 * 15), 8'(15 * 15)};
    mid_exp = 9'(15 * 15 + 15 * 15);
    set_in(1, 8'h00, 8'h37, 0, 1);
    tick();
    set_in(0, 8'h00, 8'h00, 0, 0);
    drain(0);
    check("t2_pp_hold", 64'(dut.s2_q.data), 64'(pp_exp));
    check("t2_mid_hold", 64'(dut.mid_q), 64'(mid_exp));
`ifdef VEDIC_SKIP_CNT_EN
    check("t2_skip_cnt", 64'(skip_cnt), 64'(exp_skip_cnt));
    check("t2_skip_cnt_one", 64'(skip_cnt), 64'd1);
`endif

    // Test 4: downstream stalled while the source keeps offering beats
    m_axis_tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 8'(acc + 1), 8'(acc + 3), 0, 0);
      tick();
      if (in_fire) acc++;
    end
    check("t4_accepted", 64'(acc), 64'd3);
    check("t4_s_tready_low", 64'(s_axis_tready), 64'd0);
    set_in(0, 8'h00, 8'h00, 0, 0);
    drain(0);

    // Test 3: 16 random beats, tlast on the last, random downstream ready
    for (int i = 0; i < 16; i++) begin
      ra[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rb[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      ru[i] = 1'($urandom);
    end
    idx = 0;
    n   = 0;
    while (idx < 16 && n < 400) begin
      set_in(1, ra[idx], rb[idx], idx == 15, ru[idx]);
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      if (in_fire) idx++;
      n++;
    end
    check("t3_all_accepted", 64'(idx), 64'd16);
    set_in(0, 8'h00, 8'h00, 0, 0);
    drain(1);
`ifdef VEDIC_SKIP_CNT_EN
    check("t3_skip_cnt", 64'(skip_cnt), 64'(exp_skip_cnt));

    // Clear coinciding with a bypass emission: clear wins
    skip_cnt_clr = 1'b1;
    set_in(1, 8'h05, 8'h00, 0, 0);
    tick();
    set_in(0, 8'h00, 8'h00, 0, 0);
    drain(0);
    check("cnt_clr_priority", 64'(skip_cnt), 64'd0);
    skip_cnt_clr = 1'b0;
    set_in(1, 8'h00, 8'h00, 0, 0);
    tick();
    set_in(0, 8'h00, 8'h00, 0, 0);
    drain(0);
    check("cnt_after_clr", 64'(skip_cnt), 64'(exp_skip_cnt));
`endif

    // Test 5: asynchronous reset with three beats in flight
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 8'(i + 7), 8'(i + 9), i == 2, 1);
      tick();
    end
    set_in(0, 8'h00, 8'h00, 0, 0);
    check("t5_in_flight", 64'(m_axis_tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_async");
    q.delete();
`ifdef VEDIC_SKIP_CNT_EN
    exp_skip_cnt = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("t5_release");
    m_axis_tready = 1'b1;
    set_in(1, 8'h12, 8'h34, 0, 0);
    tick();
    set_in(0, 8'h00, 8'h00, 0, 0);
    lat = 1;
    while (!m_axis_tvalid && lat < 8) begin
      tick();
      lat++;
    end
    check("t5_latency", 64'(lat), 64'd3);
    check("t5_tdata", 64'(m_axis_tdata), 64'h03A8);
    drain(0);

    // Test 6: back-to-back beats leave on consecutive cycles
    out_stamp.delete();
    m_axis_tready = 1'b1;
    acc = 0;
    set_in(1, 8'h0F, 8'h10, 0, 0);
    tick();
    if (in_fire) acc++;
    set_in(1, 8'h80, 8'h02, 0, 0);
    tick();
    if (in_fire) acc++;
    set_in(0, 8'h00, 8'h00, 0, 0);
    check("t6_accepted", 64'(acc), 64'd2);
    n = 0;
    while (!m_axis_tvalid && n < 8) begin
      tick();
      n++;
    end
    check("t6_first", 64'(m_axis_tdata), 64'h00F0);
    tick();
    check("t6_second", 64'(m_axis_tdata), 64'h0100);
    drain(0);
    check("t6_emitted", 64'(out_stamp.size()), 64'd2);
    if (out_stamp.size() == 2)
      check("t6_consecutive", 64'(out_stamp[1] - out_stamp[0]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
